ipr_arb: RTL and testbench
==========================

IPR_ARB -- requirements
Module: ipr_arb

Interface
REQ-001: Parameter NUM_PORTS, default 4, number of LSU requester ports; legal range 2..8.
REQ-002: Parameter DW, default 32, data width.
REQ-003: clk  input  1  clock; all state on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: s_req  input  NUM_PORTS  per-port request; once raised, held until the matching s_gnt bit is seen.
REQ-006: s_we  input  NUM_PORTS  per-port direction; 1 = write, 0 = read.
REQ-007: s_wdata  input  NUM_PORTS*DW  per-port write data; port i occupies bits [i*DW +: DW].
REQ-008: s_gnt  output  NUM_PORTS  per-port grant pulse.
REQ-009: s_rvalid  output  NUM_PORTS  per-port response-valid pulse.
REQ-010: s_rdata  output  DW  shared read data; valid only for the port whose s_rvalid bit is 1.
REQ-011: m_req, m_we, m_wdata  output  1/1/DW  single request toward the shared IPR FIFO.
REQ-012: m_gnt, m_rvalid, m_rdata  input  1/1/DW  FIFO grant, response-valid and read data.
REQ-013: busy  output  1  high whenever the FSM is not in IDLE.
REQ-014: txn_cnt  output  16  count of completed transactions.

Function
REQ-015: The FSM shall have exactly three states: IDLE, ISSUE and WAIT.
REQ-016: In IDLE with any s_req bit set, the FSM shall latch the winner index sel, its s_we and its s_wdata, then go to ISSUE on the next cycle.
REQ-017: The winner shall be chosen round-robin: the first set s_req bit, searching upward from index (last_granted+1) mod NUM_PORTS.
REQ-018: In ISSUE, m_req shall be 1 and m_we/m_wdata shall show the latched values; m_req, m_we and m_wdata shall be 0 in every other state.
REQ-019: In ISSUE, s_gnt[sel] shall equal m_gnt combinationally; all other s_gnt bits shall be 0.
REQ-020: On m_gnt=1 in ISSUE, the FSM shall set last_granted to sel and go to WAIT.
REQ-021: ISSUE shall hold with no time limit while m_gnt=0; this covers FIFO full on writes and FIFO empty on reads.
REQ-022: In WAIT, s_rvalid[sel] shall equal m_rvalid.
REQ-023: s_rdata shall equal m_rdata at all times.
REQ-024: On m_rvalid=1 in WAIT, txn_cnt shall increment and the FSM shall return to IDLE.
REQ-025: m_rvalid seen outside WAIT shall be ignored: no s_rvalid and no count change.
REQ-026: Minimum transaction length shall be 3 cycles (IDLE select, ISSUE with same-cycle m_gnt, WAIT with next-cycle m_rvalid); back-to-back transactions shall therefore start every 3 cycles.
REQ-027: At most one transaction shall be outstanding.
REQ-028: New or changed s_req/s_we/s_wdata inputs after latching shall not affect the transaction in flight.
REQ-029: txn_cnt shall wrap from 16'hFFFF to 0.
REQ-030: The round-robin pointer shall wrap from NUM_PORTS-1 to 0.

Reset
REQ-031: While rst_n=0, the following shall all be 0: state=IDLE, last_granted=NUM_PORTS-1, sel, latched data, txn_cnt, busy, m_req, s_gnt and s_rvalid.
REQ-032: Reset asserted in ISSUE or WAIT shall abandon the transaction with no s_gnt and no s_rvalid; the first arbitration after release shall start at port 0.

Verification
REQ-033: After reset, port 2 writes 32'hDEAD_BEEF, m_gnt=1 immediately, m_rvalid one cycle later -> m_req high 1 cycle with m_we=1 and m_wdata=32'hDEAD_BEEF; s_gnt=4'b0100; s_rvalid=4'b0100 the next cycle; txn_cnt=1; busy high 2 cycles.
REQ-034: All 4 ports request continuously after reset -> grant order 0,1,2,3,0; each s_gnt bit pulses once per 3-cycle transaction.
REQ-035: Port 1 reads while m_gnt is held 0 for 10 cycles -> m_req stays high for 10 cycles, s_gnt=0 throughout; m_gnt then rises -> s_gnt[1] pulses, s_rvalid[1] pulses with s_rdata=m_rdata=32'h0000_00A5.
REQ-036: Spurious m_rvalid in IDLE and ISSUE -> s_rvalid stays 0 and txn_cnt is unchanged.
REQ-037: rst_n asserted in WAIT -> all outputs 0 immediately; after release, ports 0 and 3 pending -> port 0 is granted first.
REQ-038: txn_cnt preloaded to 16'hFFFF by running 65535 transactions, then one more transaction -> txn_cnt=0.

Source files
------------

// File: rtl/ipr_arb.sv
// Round-robin arbiter funnelling NUM_PORTS LSU requesters onto one IPR FIFO port, one transaction in flight.
// Minimum 3 cycles per transaction; ISSUE stalls indefinitely on m_gnt=0, WAIT stalls until m_rvalid.
module ipr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int DW        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    s_req,
  input  logic [NUM_PORTS-1:0]    s_we,
  input  logic [NUM_PORTS*DW-1:0] s_wdata,
  output logic [NUM_PORTS-1:0]    s_gnt,
  output logic [NUM_PORTS-1:0]    s_rvalid,
  output logic [DW-1:0]           s_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [DW-1:0]           m_wdata,
  input  logic                    m_gnt,
  input  logic                    m_rvalid,
  input  logic [DW-1:0]           m_rdata,
  output logic                    busy,
  output logic [15:0]             txn_cnt
);
  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [IW-1:0]   win;
  logic            found;

  // Search upward from the port after the last one granted.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(last_q) + 1 + i) % NUM_PORTS);
      if (!found && s_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          we_d    = s_we[win];
          wdata_d = s_wdata[int'(win)*DW +: DW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_gnt) begin
          last_d  = sel_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_PORTS - 1);
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from the state register so an async reset clears them at once.
  always_comb begin
    m_req    = (state_q == ISSUE);
    m_we     = (state_q == ISSUE) && we_q;
    m_wdata  = (state_q == ISSUE) ? wdata_q : '0;
    s_gnt    = (state_q == ISSUE) ? (NUM_PORTS'(m_gnt) << sel_q) : '0;
    s_rvalid = (state_q == WAIT) ? (NUM_PORTS'(m_rvalid) << sel_q) : '0;
    s_rdata  = m_rdata;
    busy     = (state_q != IDLE);
    txn_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_ipr_arb.sv
// Directed bench for ipr_arb with hand-computed expectations at each step.
module tb_ipr_arb;
  logic         clk;
  logic         rst_n;
  logic [3:0]   s_req;
  logic [3:0]   s_we;
  logic [127:0] s_wdata;
  logic [3:0]   s_gnt;
  logic [3:0]   s_rvalid;
  logic [31:0]  s_rdata;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_wdata;
  logic         m_gnt;
  logic         m_rvalid;
  logic [31:0]  m_rdata;
  logic         busy;
  logic [15:0]  txn_cnt;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  ipr_arb #(.NUM_PORTS(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req(s_req), .s_we(s_we), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_req(m_req), .m_we(m_we), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with every input active: nothing may leak out.
    rst_n = 1'b0; s_req = 4'hF; s_we = 4'hF; s_wdata = '1;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_mreq", m_req, 0);
    chk("rst_sgnt", s_gnt, 0);
    chk("rst_srvalid", s_rvalid, 0);
    chk("rst_txncnt", txn_cnt, 0);
    chk("rst_mwdata", m_wdata, 0);
    s_req = '0; s_we = '0; s_wdata = '0; m_gnt = 1'b0; m_rvalid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Port 2 write, immediate grant, response one cycle later.
    s_req = 4'b0100; s_we = 4'b0100; s_wdata[64 +: 32] = 32'hDEAD_BEEF; m_gnt = 1'b1;
    #1;
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_mreq", m_req, 0);
    cyc();
    s_wdata[64 +: 32] = 32'h1111_2222;
    s_we = 4'b0000;
    #1;
    chk("wr_mreq", m_req, 1);
    chk("wr_mwe", m_we, 1);
    chk("wr_mwdata", m_wdata, 32'hDEAD_BEEF);
    chk("wr_sgnt", s_gnt, 4'b0100);
    chk("wr_busy1", busy, 1);
    s_req = '0;
    cyc();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    chk("wr_srvalid", s_rvalid, 4'b0100);
    chk("wr_srdata", s_rdata, 32'h1234_5678);
    chk("wr_wait_mreq", m_req, 0);
    chk("wr_wait_sgnt", s_gnt, 0);
    chk("wr_busy2", busy, 1);
    cyc();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    chk("wr_txncnt", txn_cnt, 1);
    chk("wr_busy_end", busy, 0);
    chk("wr_srvalid_end", s_rvalid, 0);

    // All four ports request continuously after reset.
    do_reset();
    s_req = 4'hF; s_we = 4'h0; m_gnt = 1'b1; m_rvalid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_idle_sgnt", s_gnt, 0);
      cyc();
      chk("rr_sgnt", s_gnt, order[k]);
      chk("rr_issue_srvalid", s_rvalid, 0);
      cyc();
      chk("rr_srvalid", s_rvalid, order[k]);
      chk("rr_wait_sgnt", s_gnt, 0);
      cyc();
    end
    s_req = '0; m_gnt = 1'b0; m_rvalid = 1'b0;
    #1;
    chk("rr_txncnt", txn_cnt, 5);

    // Port 1 read stalled by the FIFO for 10 cycles.
    do_reset();
    s_req = 4'b0010; s_we = 4'b0000; m_gnt = 1'b0; m_rvalid = 1'b0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      chk("stall_mreq", m_req, 1);
      chk("stall_sgnt", s_gnt, 0);
      chk("stall_mwe", m_we, 0);
      cyc();
    end
    m_gnt = 1'b1;
    #1;
    chk("stall_sgnt_rise", s_gnt, 4'b0010);
    s_req = '0;
    cyc();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_00A5;
    #1;
    chk("stall_srvalid", s_rvalid, 4'b0010);
    chk("stall_srdata", s_rdata, 32'h0000_00A5);
    cyc();
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    chk("stall_txncnt", txn_cnt, 1);
    chk("stall_busy", busy, 0);

    // Spurious m_rvalid in IDLE and ISSUE.
    m_rvalid = 1'b1;
    #1;
    chk("spur_idle_srvalid", s_rvalid, 0);
    cyc();
    chk("spur_idle_txncnt", txn_cnt, 1);
    s_req = 4'b0001;
    cyc();
    chk("spur_issue_srvalid", s_rvalid, 0);
    cyc();
    chk("spur_issue_txncnt", txn_cnt, 1);
    chk("spur_issue_mreq", m_req, 1);
    m_gnt = 1'b1; m_rvalid = 1'b0;
    #1;
    chk("spur_sgnt", s_gnt, 4'b0001);
    s_req = '0;
    cyc();
    m_gnt = 1'b0; m_rvalid = 1'b1;
    cyc();
    m_rvalid = 1'b0;
    #1;
    chk("spur_txncnt_done", txn_cnt, 2);

    // Reset asserted while waiting for the response.
    s_req = 4'b0010; m_gnt = 1'b1;
    cyc();
    s_req = '0;
    cyc();
    m_gnt = 1'b0;
    #1;
    chk("rw_busy_wait", busy, 1);
    rst_n = 1'b0; m_rvalid = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_mreq", m_req, 0);
    chk("rw_mwe", m_we, 0);
    chk("rw_mwdata", m_wdata, 0);
    chk("rw_sgnt", s_gnt, 0);
    chk("rw_srvalid", s_rvalid, 0);
    chk("rw_srdata", s_rdata, 0);
    chk("rw_txncnt", txn_cnt, 0);
    cyc();
    rst_n = 1'b1; m_rvalid = 1'b0; s_req = 4'b1001; m_gnt = 1'b1;
    cyc();
    chk("rw_first_gnt", s_gnt, 4'b0001);
    s_req = 4'b1000;
    cyc();
    m_rvalid = 1'b1;
    cyc();
    m_rvalid = 1'b0;
    cyc();
    chk("rw_second_gnt", s_gnt, 4'b1000);
    s_req = '0;
    cyc();
    m_rvalid = 1'b1;
    cyc();
    m_rvalid = 1'b0; m_gnt = 1'b0;
    #1;
    chk("rw_txncnt_done", txn_cnt, 2);

    // Counter wrap: start from 16'hFFFF and complete one more transaction.
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_pre", txn_cnt, 16'hFFFF);
    s_req = 4'b0001; m_gnt = 1'b1;
    cyc();
    s_req = '0;
    cyc();
    m_rvalid = 1'b1;
    #1;
    chk("wrap_last_srvalid", s_rvalid, 4'b0001);
    cyc();
    m_rvalid = 1'b0; m_gnt = 1'b0;
    #1;
    chk("wrap_txncnt", txn_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
